// File: rtl/collatz_sweep_ctrl_if.sv
// Job handshake between the sweep sequencer (master) and the shared Collatz engine (slave).
// One-cycle core_start launches core_n; core_count is read when core_busy falls.
interface collatz_sweep_ctrl_if #(
  parameter int W  = 8,
  parameter int CW = 8
);
  logic          core_start;
  logic [W-1:0]  core_n;
  logic          core_busy;
  logic [CW-1:0] core_count;

  modport master (output core_start, core_n, input core_busy, core_count);
  modport slave  (input core_start, core_n, output core_busy, core_count);
endinterface

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps n = range_lo..range_hi through one Collatz engine and keeps the n with the longest trajectory.
// Go to done takes 5 + engine-cycles for a single n; abort returns to IDLE without done.
module collatz_sweep_ctrl #(
  parameter int W       = 8,
  parameter int CW      = 8,
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 abort,
  input  logic [W-1:0]         range_lo,
  input  logic [W-1:0]         range_hi,
  collatz_sweep_ctrl_if.master core,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [W-1:0]         best_n,
  output logic [CW-1:0]        best_count,
  output logic [W-1:0]         jobs_done
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_B, S_WAIT_D, S_NEXT, S_FIN
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  hi;
  logic [W:0]    cur;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          tmo;

  assign accept = go && !abort;
  assign tmo    = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = (range_lo > range_hi) ? S_FIN : S_CHECK;
      // Hold off a launch while an abandoned job from an aborted sweep is still running.
      S_CHECK:  if (cur < (W+1)'(2)) state_nx = S_NEXT;
                else if (!core.core_busy) state_nx = S_ISSUE;
      S_ISSUE:  state_nx = S_WAIT_B;
      S_WAIT_B: if (core.core_busy) state_nx = S_WAIT_D;
                else if (tmo) state_nx = S_FIN;
      S_WAIT_D: if (!core.core_busy) state_nx = S_NEXT;
      S_NEXT:   state_nx = (cur[W-1:0] == hi) ? S_FIN : S_CHECK;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi         <= '0;
      cur        <= '0;
      tcnt       <= '0;
      err        <= 1'b0;
      best_n     <= '0;
      best_count <= '0;
      jobs_done  <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          hi         <= range_hi;
          cur        <= {1'b0, range_lo};
          err        <= 1'b0;
          best_n     <= '0;
          best_count <= '0;
          jobs_done  <= '0;
        end
        S_ISSUE: tcnt <= '0;
        S_WAIT_B: if (!abort && !core.core_busy) begin
          if (tmo) err <= 1'b1;
          else     tcnt <= tcnt + 1'b1;
        end
        // Strictly greater: on a tie the earlier (smaller) n is kept.
        S_WAIT_D: if (!abort && !core.core_busy && core.core_count > best_count) begin
          best_count <= core.core_count;
          best_n     <= cur[W-1:0];
        end
        // Compare against hi before incrementing so hi = 2^W-1 never wraps.
        S_NEXT: if (!abort) begin
          jobs_done <= jobs_done + 1'b1;
          if (cur[W-1:0] != hi) cur <= cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state != S_IDLE);
  assign done            = (state == S_FIN);
  assign core.core_start = (state == S_ISSUE);
  assign core.core_n     = cur[W-1:0];
endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
module tb_collatz_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] range_lo = '0;
  logic [7:0] range_hi = '0;
  logic       busy, done, err;
  logic [7:0] best_n, best_count, jobs_done;

  int errors = 0;
  int checks = 0;

  collatz_sweep_ctrl_if #(.W(8), .CW(8)) eng_if ();

  collatz_sweep_ctrl #(.W(8), .CW(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .range_lo(range_lo), .range_hi(range_hi), .core(eng_if),
    .busy(busy), .done(done), .err(err),
    .best_n(best_n), .best_count(best_count), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Engine model: mode 0 = true Collatz step count, 1 = constant count 5, 2 = never responds.
  int eng_mode = 0;
  int eng_d    = 2;
  int eng_left = 0;

  function automatic int steps(input int n);
    int x = n;
    int c = 0;
    while (x > 1) begin
      if (x % 2 == 0) x = x / 2;
      else            x = 3 * x + 1;
      c++;
    end
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_if.core_busy  <= 1'b0;
      eng_if.core_count <= '0;
      eng_left          <= 0;
    end else if (eng_if.core_start && !eng_if.core_busy && eng_mode != 2) begin
      eng_if.core_busy  <= 1'b1;
      eng_left          <= eng_d;
      eng_if.core_count <= (eng_mode == 1) ? 8'd5 : 8'(steps(int'(eng_if.core_n)));
    end else if (eng_if.core_busy) begin
      if (eng_left <= 1) eng_if.core_busy <= 1'b0;
      eng_left <= eng_left - 1;
    end
  end

  // Event monitor: cyc is the index of the cycle in progress between posedges.
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int start_cnt = 0, start_cyc = 0;
  int overlap_cnt = 0;
  always @(posedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (eng_if.core_start) begin start_cnt++; start_cyc = cyc; end
    if (eng_if.core_start && eng_if.core_busy) overlap_cnt++;
    cyc++;
  end

  task automatic run_sweep(input string name, input logic [7:0] l, input logic [7:0] h,
                           input int budget, output int go_c);
    int  d0;
    bit  to;
    d0 = done_cnt;
    @(negedge clk);
    range_lo = l; range_hi = h; go = 1'b1; go_c = cyc;
    @(negedge clk);
    go = 1'b0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s_done_timeout: no done within %0d cycles, required done", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, best_n, best_count, jobs_done, eng_if.core_start, eng_if.core_n} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b best_n=%0d best_count=%0d jobs=%0d start=%b n=%0d, required all 0",
               busy, done, err, best_n, best_count, jobs_done, eng_if.core_start, eng_if.core_n);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep_1_10();
    int g, d0, s0;
    d0 = done_cnt; s0 = start_cnt;
    eng_mode = 0; eng_d = 2;
    fork
      run_sweep("sweep_1_10", 8'd1, 8'd10, 500, g);
      begin
        repeat (12) @(negedge clk);
        range_lo = 8'd200; range_hi = 8'd210; go = 1'b1;
        @(negedge clk);
        go = 1'b0; range_lo = 8'd1; range_hi = 8'd10;
      end
    join
    checks++;
    if (best_n !== 8'd9 || best_count !== 8'd19) begin
      errors++;
      $display("FAIL sweep_1_10_best: got n=%0d count=%0d, required n=9 count=19", best_n, best_count);
    end
    checks++;
    if (jobs_done !== 8'd10) begin
      errors++;
      $display("FAIL sweep_1_10_jobs: got %0d, required 10", jobs_done);
    end
    checks++;
    if (done_cnt - d0 !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL sweep_1_10_done_err: got %0d done pulses err=%b, required 1 pulse err=0", done_cnt - d0, err);
    end
    checks++;
    if (start_cnt - s0 !== 9) begin
      errors++;
      $display("FAIL sweep_1_10_starts: got %0d, required 9 (n=1 skipped)", start_cnt - s0);
    end
  endtask

  task automatic test_sweep_1_7_and_tie();
    int g;
    eng_mode = 0; eng_d = 1;
    run_sweep("sweep_1_7", 8'd1, 8'd7, 400, g);
    checks++;
    if (best_n !== 8'd7 || best_count !== 8'd16) begin
      errors++;
      $display("FAIL sweep_1_7_best: got n=%0d count=%0d, required n=7 count=16", best_n, best_count);
    end
    eng_mode = 1;
    run_sweep("tie", 8'd2, 8'd3, 200, g);
    checks++;
    if (best_n !== 8'd2 || best_count !== 8'd5) begin
      errors++;
      $display("FAIL tie_keeps_first: got n=%0d count=%0d, required n=2 count=5", best_n, best_count);
    end
    eng_mode = 0;
  endtask

  task automatic test_empty_and_zero();
    int g, s0;
    s0 = start_cnt;
    run_sweep("lo_gt_hi", 8'd5, 8'd3, 20, g);
    checks++;
    if (done_cyc - g + 1 !== 2) begin
      errors++;
      $display("FAIL lo_gt_hi_latency: go..done span %0d cycles, required 2", done_cyc - g + 1);
    end
    checks++;
    if (jobs_done !== 8'd0 || start_cnt != s0) begin
      errors++;
      $display("FAIL lo_gt_hi_jobs: jobs=%0d starts=%0d, required 0 and 0", jobs_done, start_cnt - s0);
    end
    run_sweep("zero", 8'd0, 8'd0, 20, g);
    checks++;
    if (jobs_done !== 8'd1 || start_cnt != s0 || best_n !== 8'd0) begin
      errors++;
      $display("FAIL zero_skip: jobs=%0d starts=%0d best_n=%0d, required 1, 0, 0", jobs_done, start_cnt - s0, best_n);
    end
  endtask

  task automatic test_latency();
    int g;
    eng_mode = 0; eng_d = 3;
    run_sweep("latency", 8'd9, 8'd9, 50, g);
    checks++;
    if (done_cyc - g !== 8) begin
      errors++;
      $display("FAIL single_latency: go to done %0d cycles, required 8 (5 + D=3)", done_cyc - g);
    end
  endtask

  task automatic test_top_range();
    int g, d0, s0, bc, bn;
    d0 = done_cnt; s0 = start_cnt;
    eng_mode = 0; eng_d = 1;
    bc = 0; bn = 0;
    for (int n = 250; n <= 255; n++) if (steps(n) > bc) begin bc = steps(n); bn = n; end
    run_sweep("top_range", 8'd250, 8'd255, 2000, g);
    repeat (10) @(negedge clk);
    checks++;
    if (start_cnt - s0 !== 6 || done_cnt - d0 !== 1 || jobs_done !== 8'd6) begin
      errors++;
      $display("FAIL top_range_no_wrap: starts=%0d dones=%0d jobs=%0d, required 6, 1, 6",
               start_cnt - s0, done_cnt - d0, jobs_done);
    end
    checks++;
    if (int'(best_n) !== bn || int'(best_count) !== bc) begin
      errors++;
      $display("FAIL top_range_best: got n=%0d count=%0d, required n=%0d count=%0d", best_n, best_count, bn, bc);
    end
  endtask

  task automatic test_timeout();
    int g;
    eng_mode = 2;
    run_sweep("timeout", 8'd5, 8'd5, 50, g);
    checks++;
    if (err !== 1'b1 || done_cyc - start_cyc !== 5) begin
      errors++;
      $display("FAIL timeout_err: err=%b start..done %0d cycles, required err=1 and 5", err, done_cyc - start_cyc);
    end
    eng_mode = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b, required 1", err);
    end
    run_sweep("err_clear", 8'd1, 8'd1, 20, g);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_go: err=%b, required 0", err);
    end
  endtask

  task automatic test_abort_and_reset();
    int d0;
    bit found;
    eng_mode = 0; eng_d = 3;
    d0 = done_cnt;
    @(negedge clk);
    range_lo = 8'd1; range_hi = 8'd10; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (eng_if.core_busy && eng_if.core_n == 8'd6) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach_n6: job n=6 not seen in 300 cycles, required seen");
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_to_idle: busy=%b, required 0", busy);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt != d0 || jobs_done !== 8'd5 || best_n !== 8'd3 || best_count !== 8'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_partials: dones=%0d jobs=%0d best_n=%0d count=%0d busy=%b, required 0, 5, 3, 7, 0",
               done_cnt - d0, jobs_done, best_n, best_count, busy);
    end
    // go and abort together in IDLE: abort wins.
    range_lo = 8'd1; range_hi = 8'd4; go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || jobs_done !== 8'd5) begin
      errors++;
      $display("FAIL go_abort_same_cycle: busy=%b jobs=%0d, required 0 and 5", busy, jobs_done);
    end
    range_lo = 8'd1; range_hi = 8'd10; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || best_n === 8'd0) begin
      errors++;
      $display("FAIL midsweep_state: busy=%b best_n=%0d, required busy=1 best_n nonzero", busy, best_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, best_n, best_count, jobs_done, eng_if.core_start, eng_if.core_n} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b err=%b best_n=%0d count=%0d jobs=%0d start=%b n=%0d, required all 0",
               busy, done, err, best_n, best_count, jobs_done, eng_if.core_start, eng_if.core_n);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sweep_1_10();
    test_sweep_1_7_and_tie();
    test_empty_and_zero();
    test_latency();
    test_top_range();
    test_timeout();
    test_abort_and_reset();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL start_while_busy: %0d launches while engine busy, required 0", overlap_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
